// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared tap count, default coefficients, FSM encoding and saturation limits
package fir_pkg;

  localparam int NUM_TAPS = 19;

  // Symmetric low-pass prototype; centre tap at index 9.
  localparam logic signed [15:0] DEFAULT_COEFS [NUM_TAPS] = '{
    16'sd26,    16'sd270,   16'sd963,   16'sd2424,  16'sd4869,
    16'sd8259,  16'sd12194, 16'sd15948, 16'sd18666, 16'sd19660,
    16'sd18666, 16'sd15948, 16'sd12194, 16'sd8259,  16'sd4869,
    16'sd2424,  16'sd963,   16'sd270,   16'sd26
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Largest value representable in a signed field of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Reset value for tap k; taps beyond the prototype length start at zero.
  function automatic logic signed [15:0] default_coef(input int k);
    if (k >= 0 && k < NUM_TAPS) begin
      return DEFAULT_COEFS[k];
    end
    return '0;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - combinational full-precision multiply-accumulate step
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;

  // Exact signed product, sign-extended into the accumulator width.
  always_comb begin
    prod  = x_i * coef_i;
    sum_o = acc_i + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - single-MAC time-shared FIR filter with stream in/out
module fir_mac_sequencer #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = fir_pkg::NUM_TAPS,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_data_tvalid,
  input  logic signed [DATA_W-1:0] s_axis_data_tdata,
  output logic                     s_axis_data_tready,
  output logic                     m_axis_data_tvalid,
  output logic signed [DATA_W-1:0] m_axis_data_tdata,
  input  logic                     m_axis_data_tready,
  input  logic                     coef_wr_en,
  input  logic [4:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     busy
);
  import fir_pkg::*;

  localparam logic [4:0] LAST_TAP  = 5'(NUM_TAPS - 1);
  localparam logic [4:0] TAP_LIMIT = 5'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_W));

  state_e                   state_q, state_d;
  logic [4:0]               tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] tdata_q, tdata_d;
  logic signed [DATA_W-1:0] x_q    [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic                     sample_accept;
  logic                     coef_accept;

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .acc_i  (acc_q),
    .x_i    (x_q[tap_q]),
    .coef_i (coef_q[tap_q]),
    .sum_o  (mac_sum)
  );

  assign s_axis_data_tready = (state_q == ST_IDLE);
  assign m_axis_data_tvalid = (state_q == ST_OUT);
  assign m_axis_data_tdata  = tdata_q;
  assign busy               = (state_q != ST_IDLE);
  assign sample_accept      = (state_q == ST_IDLE) && s_axis_data_tvalid;
  assign coef_accept        = (state_q == ST_IDLE) && coef_wr_en && (coef_addr < TAP_LIMIT);
  assign shifted            = mac_sum >>> OUT_SHIFT;

  // Next-state: one tap per MAC cycle; result is latched on the final tap as OUT is entered.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    tdata_d = tdata_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_accept) begin
          state_d = ST_MAC;
          tap_d   = '0;
          acc_d   = '0;
        end
      end
      ST_MAC: begin
        acc_d = mac_sum;
        if (tap_q == LAST_TAP) begin
          state_d = ST_OUT;
          tap_d   = '0;
          tdata_d = saturate(shifted);
        end else begin
          tap_d = tap_q + 5'd1;
        end
      end
      ST_OUT: begin
        if (m_axis_data_tready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      tdata_q <= tdata_d;
    end
  end

  // Sample delay line; shifts only when a new sample is accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
    end else if (sample_accept) begin
      x_q[0] <= s_axis_data_tdata;
      for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Coefficient store; writable only while idle so a running sum never sees a mixed set.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= COEF_W'(default_coef(k));
    end else if (coef_accept) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;

  localparam int NTAPS = 19;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               s_tvalid;
  logic signed [15:0] s_tdata;
  logic               m_tready;
  logic               coef_wr_en;
  logic [4:0]         coef_addr;
  logic signed [15:0] coef_wdata;

  logic               s_tready0, m_tvalid0, busy0;
  logic signed [15:0] m_tdata0;
  logic               s_tready1, m_tvalid1, busy1;
  logic signed [15:0] m_tdata1;

  int n_compared   = 0;
  int n_mismatched = 0;

  int coefs [NTAPS] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                        18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};

  always #5 aclk = ~aclk;

  // Unshifted instance exposes raw tap values; default instance checks OUT_SHIFT=15.
  fir_mac_sequencer #(.OUT_SHIFT(0)) u_dut_s0 (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tready (s_tready0),
    .m_axis_data_tvalid (m_tvalid0),
    .m_axis_data_tdata  (m_tdata0),
    .m_axis_data_tready (m_tready),
    .coef_wr_en         (coef_wr_en),
    .coef_addr          (coef_addr),
    .coef_wdata         (coef_wdata),
    .busy               (busy0)
  );

  fir_mac_sequencer u_dut_s15 (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tready (s_tready1),
    .m_axis_data_tvalid (m_tvalid1),
    .m_axis_data_tdata  (m_tdata1),
    .m_axis_data_tready (m_tready),
    .coef_wr_en         (coef_wr_en),
    .coef_addr          (coef_addr),
    .coef_wdata         (coef_wdata),
    .busy               (busy1)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge with both DUTs idle; ends at a falling edge back in idle.
  // Cycle 0 is the accepting cycle, so the result must appear in cycle NTAPS+1.
  task automatic run_sample(input string tag, input logic signed [15:0] v,
                            input bit chk0, input int exp0, input bit chk15, input int exp15,
                            input bit wr_idle, input bit wr_mac,
                            input logic [4:0] waddr, input logic signed [15:0] wdata);
    int cyc;
    check({tag, ".s_tready"}, s_tready0, 1);
    s_tvalid = 1'b1;
    s_tdata  = v;
    m_tready = 1'b1;
    if (wr_idle) begin
      coef_wr_en = 1'b1; coef_addr = waddr; coef_wdata = wdata;
    end
    @(negedge aclk);
    s_tvalid   = 1'b0;
    coef_wr_en = 1'b0;
    cyc        = 1;
    if (wr_mac) begin
      coef_wr_en = 1'b1; coef_addr = waddr; coef_wdata = wdata;
      @(negedge aclk);
      coef_wr_en = 1'b0;
      cyc++;
    end
    while (!m_tvalid0 && cyc < 60) begin
      @(negedge aclk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, NTAPS + 1);
    if (chk0)  check({tag, ".out_s0"}, m_tdata0, exp0);
    if (chk15) check({tag, ".out_s15"}, m_tdata1, exp15);
    @(negedge aclk);
    check({tag, ".tvalid_drop"}, m_tvalid0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    aresetn    = 1'b0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    m_tready   = 1'b0;
    coef_wr_en = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;

    // Reset state.
    repeat (3) @(negedge aclk);
    check("rst.tvalid", m_tvalid0, 0);
    check("rst.tdata", m_tdata0, 0);
    check("rst.busy", busy0, 0);
    check("rst.busy_s15", busy1, 0);
    aresetn = 1'b1;
    #1;
    check("rst.s_tready_first", s_tready0, 1);

    // Impulse response; coef[9]=0 written during the first MAC must be ignored,
    // and an out-of-range idle write must be ignored too.
    for (int j = 0; j < NTAPS; j++) begin
      run_sample($sformatf("imp%0d", j), (j == 0) ? 16'sd1 : 16'sd0,
                 1'b1, coefs[j], 1'b1, 0,
                 (j == 1), (j == 0), (j == 1) ? 5'd19 : 5'd9, 16'sd0);
    end

    // Backpressure: x0=2 after the impulse has left the line -> 2*26=52.
    // A sample offered while busy must not be stored.
    check("bp.s_tready", s_tready0, 1);
    s_tvalid = 1'b1;
    s_tdata  = 16'sd2;
    m_tready = 1'b0;
    @(negedge aclk);
    s_tdata = 16'sd1234;
    cyc = 1;
    while (!m_tvalid0 && cyc < 60) begin
      @(negedge aclk);
      cyc++;
    end
    check("bp.latency", cyc, NTAPS + 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp.tvalid%0d", i), m_tvalid0, 1);
      check($sformatf("bp.tdata%0d", i), m_tdata0, 52);
      check($sformatf("bp.tdata_s15_%0d", i), m_tdata1, 0);
      check($sformatf("bp.s_tready%0d", i), s_tready0, 0);
      @(negedge aclk);
    end
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check("bp.done_tvalid", m_tvalid0, 0);
    check("bp.done_s_tready", s_tready0, 1);

    // Positive saturation. First: 32767*26 + 2*270 = 852482 -> >>>15 = 26.
    for (int j = 0; j < NTAPS; j++) begin
      run_sample($sformatf("satp%0d", j), 16'sd32767,
                 (j == 0) || (j == NTAPS - 1), 32767,
                 (j == 0) || (j == NTAPS - 1), (j == 0) ? 26 : 32767,
                 1'b0, 1'b0, 5'd0, 16'sd0);
    end

    // Negative saturation.
    for (int j = 0; j < NTAPS; j++) begin
      run_sample($sformatf("satn%0d", j), -16'sd32768,
                 (j == NTAPS - 1), -32768, (j == NTAPS - 1), -32768,
                 1'b0, 1'b0, 5'd0, 16'sd0);
    end

    // Reset in the middle of a MAC run at tap 7.
    check("rmid.s_tready", s_tready0, 1);
    s_tvalid = 1'b1;
    s_tdata  = 16'sd5;
    @(negedge aclk);
    s_tvalid = 1'b0;
    repeat (7) @(negedge aclk);
    check("rmid.busy_before", busy0, 1);
    aresetn = 1'b0;
    #1;
    check("rmid.tvalid", m_tvalid0, 0);
    check("rmid.tdata", m_tdata0, 0);
    check("rmid.busy", busy0, 0);
    check("rmid.s_tready", s_tready0, 1);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rmid.s_tready_release", s_tready0, 1);
    run_sample("rmid.imp", 16'sd1, 1'b1, 26, 1'b1, 0, 1'b0, 1'b0, 5'd0, 16'sd0);

    // Idle coefficient write: coef[9]=0 written with sample 9 is used by that sample.
    for (int j = 1; j <= 10; j++) begin
      run_sample($sformatf("cg%0d", j), 16'sd0,
                 1'b1, (j == 9) ? 0 : coefs[j], 1'b1, 0,
                 (j == 9), 1'b0, 5'd9, 16'sd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named aclk and aresetn.
REQ-002 The block SHALL have these parameters:
- DATA_W, 16: sample and output width, signed.
- COEF_W, 16: coefficient width, signed.
- NUM_TAPS, 19: number of filter taps.
- ACC_W, 40: accumulator width, signed.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- aclk, in, 1: clock.
- aresetn, in, 1: async active-low reset.
- s_axis_data_tvalid, in, 1: input sample valid.
- s_axis_data_tdata, in, DATA_W: input sample.
- s_axis_data_tready, out, 1: block can accept a sample.
- m_axis_data_tvalid, out, 1: output result valid.
- m_axis_data_tdata, out, DATA_W: filtered result.
- m_axis_data_tready, in, 1: downstream accepts the result.
- coef_wr_en, in, 1: coefficient write strobe.
- coef_addr, in, 5: coefficient index, 0..NUM_TAPS-1.
- coef_wdata, in, COEF_W: coefficient value.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-004 The block SHALL time-share one multiply-accumulate unit across all taps, performing one tap per clock.
REQ-005 The FSM SHALL have exactly three states: IDLE, MAC and OUT.
REQ-006 In IDLE, s_axis_data_tready SHALL be 1; in MAC and OUT it SHALL be 0.
REQ-007 In IDLE, on the s_axis_data_tvalid && s_axis_data_tready edge, the block SHALL:
- shift the delay line (x[k] <= x[k-1], x[0] <= sample);
- clear the accumulator;
- set tap=0;
- go to MAC.
REQ-008 In MAC, each cycle SHALL compute acc <= acc + x[tap]*coef[tap] and then increment tap.
- x[0] seen in MAC is the newly captured sample.
- After tap NUM_TAPS-1 the FSM SHALL go to OUT.
REQ-009 The product SHALL be a full-precision signed DATA_W+COEF_W result, sign-extended to ACC_W; the accumulator SHALL NOT wrap for any input.
REQ-010 On entry to OUT, m_axis_data_tdata SHALL be registered as acc >>> OUT_SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-011 In OUT, m_axis_data_tvalid SHALL be 1, and m_axis_data_tdata SHALL hold stable until m_axis_data_tready=1.
- On the handshake edge the FSM SHALL go to IDLE.
REQ-012 Latency SHALL be fixed:
- Acceptance edge at cycle 0.
- m_axis_data_tvalid SHALL be high from the edge at cycle NUM_TAPS+1.
- Maximum throughput SHALL be one sample per NUM_TAPS+2 cycles.
REQ-013 A coefficient write SHALL be accepted only in IDLE with coef_addr < NUM_TAPS.
- Writes in MAC or OUT, or with an out-of-range address, SHALL be silently ignored.
REQ-014 If a coefficient write and a sample acceptance occur in the same IDLE cycle, both SHALL take effect, and the new coefficient SHALL be used for that sample.
REQ-015 m_axis_data_tready in IDLE or MAC SHALL be ignored; s_axis_data_tvalid outside IDLE SHALL be ignored and SHALL NOT be stored.

Reset
REQ-016 Asserting aresetn low SHALL immediately, including in the middle of a MAC run, set:
- FSM to IDLE;
- tap, acc and all x[k] to 0;
- m_axis_data_tvalid=0 and m_axis_data_tdata=0;
- busy=0.
The in-flight sample SHALL be discarded.
REQ-017 After reset, s_axis_data_tready SHALL be 1 in the first cycle in which aresetn is high.
REQ-018 Coefficients SHALL reset to the package defaults: 26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660, then the same values mirrored.

Structure
REQ-019 A shared package fir_pkg SHALL hold:
- NUM_TAPS;
- the default coefficient array;
- the FSM state enum;
- the saturation limits.
REQ-020 The multiply-accumulate SHALL be a separate sub-module named fir_mac_unit (operands in, sum out, combinational); the sequencer SHALL own all registers.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Impulse response: OUT_SHIFT=0; send 1, then 18 zeros, with m_axis_data_tready=1 -> outputs 26, 270, 963, ..., 19660, ..., 26, each exactly NUM_TAPS+1 cycles after its acceptance.
- Saturation: default OUT_SHIFT; send 19 samples of 32767 -> final output 32767; send 19 samples of -32768 -> final output -32768.
- Backpressure: hold m_axis_data_tready=0 for 10 cycles in OUT -> m_axis_data_tvalid and m_axis_data_tdata stay stable, s_axis_data_tready=0 throughout; output completes one cycle after m_axis_data_tready=1.
- Coefficient gating: write coef[9]=0 during MAC -> ignored; write it in IDLE -> the next impulse output at tap 9 is 0 with OUT_SHIFT=0.
- Reset mid-MAC: assert aresetn at tap 7 -> m_axis_data_tvalid=0 and s_axis_data_tready=1 after release; a following impulse of 1 gives 26 (delay line cleared).
